sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Round-robin arbiter that shares one SDRAM controller internal interface (acc/we/adr/dat/sel/dv/ack/vld) among NPORTS wb_port instances.
- Lives entirely in the sdram_clk domain, between the wb_port internal-interface outputs and the SDRAM command engine.
- Grants one port at a time, forwards its commands and write data, and steers returning read beats (vld) back to the port that issued each read, using an in-order read-owner FIFO.

Parameters:
- NPORTS, 2, number of requesting ports (2..8).
- READ_BEATS, 8, 16-bit vld beats returned per accepted read command.
- MAX_ACKS, 16, acks a granted port may consume before a forced release while another port is requesting.
- TAG_DEPTH_LOG2, 2, log2 of the outstanding-read owner FIFO depth.

Ports:
- sdram_clk  in  1  clock.
- sdram_rst_n  in  1  asynchronous, active-low reset.
- p_acc_i  in  NPORTS  per-port command request.
- p_we_i  in  NPORTS  per-port write flag.
- p_adr_i  in  32*NPORTS  per-port address, port k at [32k+31:32k].
- p_dat_i  in  16*NPORTS  per-port write data.
- p_sel_i  in  2*NPORTS  per-port byte select.
- p_dv_i  in  NPORTS  per-port write-data valid.
- p_ack_o  out  NPORTS  ack routed to the granted port.
- p_vld_o  out  NPORTS  read-beat valid routed to the owning port.
- p_dat_o  out  16  read data, broadcast to all ports.
- p_adr_o  out  32  read-beat address, broadcast to all ports.
- acc_o  out  1  command request to the controller.
- we_o  out  1  write flag to the controller.
- adr_o  out  32  address to the controller.
- dat_o  out  16  write data to the controller.
- sel_o  out  2  byte select to the controller.
- dv_o  out  1  write-data valid to the controller.
- ack_i  in  1  controller command/data ack.
- vld_i  in  1  controller read-beat valid.
- dat_i  in  16  controller read data.
- adr_i  in  32  controller read-beat address.
- grant_o  out  NPORTS  one-hot current grant (debug/status).

Behaviour:
Reset (sdram_rst_n=0, asynchronous):
- grant_o=0, acc_o=0, dv_o=0, we_o=0, adr_o=0, dat_o=0, sel_o=0, p_ack_o=0, p_vld_o=0.
- State=IDLE, rr pointer=0, ack counter=0, FIFO empty, beat counter=0.

FSM, IDLE:
- If any p_acc_i is set, select the first requester searching from (last_owner+1) mod NPORTS.
- Register the grant; go to BUSY.
- Grant is visible 1 cycle after the request (arbitration latency 1).

FSM, BUSY:
- Forwarding is combinational from the owner: acc_o, we_o, adr_o, dat_o, sel_o, dv_o.
- p_ack_o[owner]=ack_i; all other p_ack_o bits are 0.
- Release to IDLE on either of these events:
  - p_acc_i[owner]=0 and p_dv_i[owner]=0; or
  - ack_i=1, ack counter reaches MAX_ACKS-1, and another port's p_acc_i=1 (forced release).
- On release: last_owner<=owner, counter<=0, grant cleared.
- There is always exactly one idle cycle between grants.
- The ack counter increments on each ack_i in BUSY and saturates; it clears on release.

Read tagging:
- A read is accepted when acc_o & ack_i & !we_o; push the owner index into the FIFO.
- If the FIFO is full and the owner presents a read (!we): force acc_o=0, so no ack can occur. Writes are not blocked.
- On vld_i with the FIFO non-empty:
  - p_vld_o[head]=1; p_dat_o=dat_i, p_adr_o=adr_i (both pass through combinationally).
  - The beat counter increments; on READ_BEATS-1 it wraps to 0 and pops the head.
- vld_i with the FIFO empty: dropped, all p_vld_o=0 (protocol error).
- Push and pop in the same cycle are legal; the FIFO count is unchanged.
- Read return is independent of grant: a port may receive vld while another port owns the command path.

Boundaries:
- Single requester: it is regranted after the 1-cycle gap.
- All NPORTS requesting continuously: grants rotate strictly 0,1,…,NPORTS-1,0.
- ack_i outside BUSY: ignored, no p_ack_o.
- Widths: rr pointer and owner are clog2(NPORTS) bits; the beat counter is clog2(READ_BEATS) bits.

Test Plan:
- Reset: assert sdram_rst_n=0 mid-BUSY with FIFO count 2 -> all outputs 0 immediately, FIFO empty; after release, p_acc_i=01 -> grant_o=01 after 1 cycle.
- Round-robin: p_acc_i=11 held, controller acks each command and ports drop acc after 1 ack -> grant sequence 01,00,10,00,01.
- Forced release: port0 holds acc with ack_i every cycle, port1 requesting, MAX_ACKS=16 -> port0 is released after the 16th ack, next grant 10; port0 gets exactly 16 p_ack_o pulses.
- Read steering: port0 read, then port1 read accepted, controller returns 16 vld beats -> beats 0-7 on p_vld_o[0], beats 8-15 on p_vld_o[1], p_dat_o equals dat_i on each beat.
- FIFO full: 4 reads outstanding, owner issues a 5th read -> acc_o stays 0 until the first pop, then asserts; a write presented while the FIFO is full proceeds with ack.
- Simultaneous push and pop: last vld beat and a new read ack in the same cycle -> FIFO count unchanged, next vld beat routed to the new head.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller internal interface among NPORTS ports.
// Read beats are steered back to the issuing port through an in-order owner FIFO.
//
//    state   | meaning
//    --------+-----------------------------------------------------------
//    ST_IDLE | no owner; pick next requester round-robin, grant next cycle
//    ST_BUSY | owner's command/data path forwarded to the controller

module sdram_port_arbiter #(
   parameter int NPORTS         = 2,
   parameter int READ_BEATS     = 8,
   parameter int MAX_ACKS       = 16,
   parameter int TAG_DEPTH_LOG2 = 2
) (
   input  logic                  sdram_clk,
   input  logic                  sdram_rst_n,
   input  logic [NPORTS-1:0]     p_acc_i,
   input  logic [NPORTS-1:0]     p_we_i,
   input  logic [32*NPORTS-1:0]  p_adr_i,
   input  logic [16*NPORTS-1:0]  p_dat_i,
   input  logic [2*NPORTS-1:0]   p_sel_i,
   input  logic [NPORTS-1:0]     p_dv_i,
   output logic [NPORTS-1:0]     p_ack_o,
   output logic [NPORTS-1:0]     p_vld_o,
   output logic [15:0]           p_dat_o,
   output logic [31:0]           p_adr_o,
   output logic                  acc_o,
   output logic                  we_o,
   output logic [31:0]           adr_o,
   output logic [15:0]           dat_o,
   output logic [1:0]            sel_o,
   output logic                  dv_o,
   input  logic                  ack_i,
   input  logic                  vld_i,
   input  logic [15:0]           dat_i,
   input  logic [31:0]           adr_i,
   output logic [NPORTS-1:0]     grant_o
);

   localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int BW    = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
   localparam int AW    = $clog2(MAX_ACKS + 1);
   localparam int DEPTH = 1 << TAG_DEPTH_LOG2;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                 state;
   logic [PW-1:0]          owner;
   logic [PW-1:0]          rr_ptr;
   logic [AW-1:0]          ack_cnt;
   logic [PW-1:0]          pick;
   logic                   pick_vld;
   logic [NPORTS-1:0]      pick_oh;

   logic [31:0]            adr_arr [NPORTS];
   logic [15:0]            dat_arr [NPORTS];
   logic [1:0]             sel_arr [NPORTS];

   logic                   busy;
   logic                   own_acc;
   logic                   own_we;
   logic                   own_dv;
   logic                   others_req;
   logic                   rel;

   logic [PW-1:0]          tag_mem [DEPTH];
   logic [TAG_DEPTH_LOG2-1:0] wr_ptr;
   logic [TAG_DEPTH_LOG2-1:0] rd_ptr;
   logic [TAG_DEPTH_LOG2:0]   tag_cnt;
   logic [BW-1:0]          beat_cnt;
   logic [PW-1:0]          head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   beat;

   genvar k;
   generate
      for (k = 0; k < NPORTS; k++) begin : g_port
         assign adr_arr[k] = p_adr_i[32*k +: 32];
         assign dat_arr[k] = p_dat_i[16*k +: 16];
         assign sel_arr[k] = p_sel_i[2*k +: 2];
         assign pick_oh[k] = (pick == PW'(k));
         assign p_ack_o[k] = busy & ack_i & (owner == PW'(k));
         assign p_vld_o[k] = beat & (head == PW'(k));
      end
   endgenerate

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!pick_vld && p_acc_i[PW'((int'(rr_ptr) + i) % NPORTS)]) begin
            pick_vld = 1'b1;
            pick     = PW'((int'(rr_ptr) + i) % NPORTS);
         end
      end
   end

   assign busy       = (state == ST_BUSY);
   assign own_acc    = p_acc_i[owner];
   assign own_we     = p_we_i[owner];
   assign own_dv     = p_dv_i[owner];
   assign others_req = |(p_acc_i & ~grant_o);

   assign fifo_full  = (tag_cnt == (TAG_DEPTH_LOG2+1)'(DEPTH));
   assign fifo_empty = (tag_cnt == '0);
   assign head       = tag_mem[rd_ptr];

   // A read with no free owner slot is held off; writes always pass.
   assign acc_o = busy & own_acc & ~(fifo_full & ~own_we);
   assign we_o  = busy & own_we;
   assign dv_o  = busy & own_dv;
   assign adr_o = busy ? adr_arr[owner] : '0;
   assign dat_o = busy ? dat_arr[owner] : '0;
   assign sel_o = busy ? sel_arr[owner] : '0;

   assign p_dat_o = dat_i;
   assign p_adr_o = adr_i;

   assign rel = busy & ((~own_acc & ~own_dv) |
                        (ack_i & (ack_cnt == AW'(MAX_ACKS-1)) & others_req));

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         state   <= ST_IDLE;
         grant_o <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         ack_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state   <= ST_BUSY;
                  owner   <= pick;
                  grant_o <= pick_oh;
                  ack_cnt <= '0;
               end
            end
            ST_BUSY: begin
               if (rel) begin
                  state   <= ST_IDLE;
                  grant_o <= '0;
                  ack_cnt <= '0;
                  rr_ptr  <= (owner == PW'(NPORTS-1)) ? '0 : owner + 1'b1;
               end else if (ack_i && (ack_cnt != AW'(MAX_ACKS-1))) begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_o <= '0;
            end
         endcase
      end
   end

   assign push = acc_o & ack_i & ~we_o;
   assign beat = vld_i & ~fifo_empty;
   assign pop  = beat & (beat_cnt == BW'(READ_BEATS-1));

   always_ff @(posedge sdram_clk) begin
      if (push) tag_mem[wr_ptr] <= owner;
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tag_cnt  <= '0;
         beat_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
         if (beat) beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (2 ports, 8 beats/read, 16-ack limit, 4-deep owner FIFO).
module tb_sdram_port_arbiter;

   logic        sdram_clk = 1'b0;
   logic        sdram_rst_n = 1'b0;
   logic [1:0]  p_acc_i = '0;
   logic [1:0]  p_we_i = '0;
   logic [63:0] p_adr_i = '0;
   logic [31:0] p_dat_i = '0;
   logic [3:0]  p_sel_i = '0;
   logic [1:0]  p_dv_i = '0;
   logic [1:0]  p_ack_o;
   logic [1:0]  p_vld_o;
   logic [15:0] p_dat_o;
   logic [31:0] p_adr_o;
   logic        acc_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [15:0] dat_o;
   logic [1:0]  sel_o;
   logic        dv_o;
   logic        ack_i = 1'b0;
   logic        vld_i = 1'b0;
   logic [15:0] dat_i = '0;
   logic [31:0] adr_i = '0;
   logic [1:0]  grant_o;

   int n_assert = 0;
   int n_fail   = 0;
   int pulses;
   logic saw_gap, done;

   always #5 sdram_clk = ~sdram_clk;

   sdram_port_arbiter #(
      .NPORTS(2), .READ_BEATS(8), .MAX_ACKS(16), .TAG_DEPTH_LOG2(2)
   ) dut (
      .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
      .p_acc_i(p_acc_i), .p_we_i(p_we_i), .p_adr_i(p_adr_i), .p_dat_i(p_dat_i),
      .p_sel_i(p_sel_i), .p_dv_i(p_dv_i), .p_ack_o(p_ack_o), .p_vld_o(p_vld_o),
      .p_dat_o(p_dat_o), .p_adr_o(p_adr_o), .acc_o(acc_o), .we_o(we_o),
      .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .dv_o(dv_o),
      .ack_i(ack_i), .vld_i(vld_i), .dat_i(dat_i), .adr_i(adr_i), .grant_o(grant_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sdram_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      p_adr_i = {32'h2000_0200, 32'h1000_0100};
      p_dat_i = {16'hBBBB, 16'hAAAA};
      p_sel_i = 4'b1001;
      ack_i = 1'b1;
      vld_i = 1'b1;
      #2;
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_acc", acc_o, 1'b0);
      chk("rst_ack", p_ack_o, 2'b00);
      chk("rst_vld", p_vld_o, 2'b00);
      chk("rst_adr", adr_o, 32'h0);
      ack_i = 1'b0;
      vld_i = 1'b0;
      #10 sdram_rst_n = 1'b1;
      cyc();

      // round-robin: both requesting writes
      p_acc_i = 2'b11; p_we_i = 2'b11;
      #1 chk("rr_latency", grant_o, 2'b00);
      cyc();
      chk("rr_g0", grant_o, 2'b01);
      chk("fwd_adr0", adr_o, 32'h1000_0100);
      chk("fwd_dat0", dat_o, 16'hAAAA);
      chk("fwd_sel0", sel_o, 2'b01);
      ack_i = 1'b1;
      #1 chk("rr_ack0", p_ack_o, 2'b01);
      cyc();
      ack_i = 1'b0; p_acc_i = 2'b10;
      cyc();
      chk("rr_gap1", grant_o, 2'b00);
      p_acc_i = 2'b11;
      cyc();
      chk("rr_g1", grant_o, 2'b10);
      chk("fwd_adr1", adr_o, 32'h2000_0200);
      ack_i = 1'b1;
      #1 chk("rr_ack1", p_ack_o, 2'b10);
      cyc();
      ack_i = 1'b0; p_acc_i = 2'b01;
      cyc();
      chk("rr_gap2", grant_o, 2'b00);
      p_acc_i = 2'b11;
      cyc();
      chk("rr_g2", grant_o, 2'b01);

      // single requester regranted; ack outside BUSY ignored
      p_acc_i = 2'b00;
      cyc();
      chk("single_rel", grant_o, 2'b00);
      ack_i = 1'b1;
      #1 chk("idle_ack_ignored", p_ack_o, 2'b00);
      ack_i = 1'b0;
      p_acc_i = 2'b01;
      cyc();
      chk("single_regrant", grant_o, 2'b01);
      p_acc_i = 2'b00;
      cyc();

      // forced release after 16 acks
      p_acc_i = 2'b01;
      cyc();
      chk("force_g0", grant_o, 2'b01);
      p_acc_i = 2'b11; ack_i = 1'b1;
      pulses = 0; saw_gap = 1'b0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (p_ack_o[0]) pulses++;
         if (grant_o == 2'b00) saw_gap = 1'b1;
         if (grant_o == 2'b10) done = 1'b1;
         else cyc();
      end
      chk("force_ack_count", pulses, 16);
      chk("force_gap", saw_gap, 1'b1);
      chk("force_next_g1", done, 1'b1);
      ack_i = 1'b0; p_acc_i = 2'b00;
      cyc();
      chk("force_rel1", grant_o, 2'b00);

      // read steering: port0 read then port1 read
      p_we_i = 2'b00; p_acc_i = 2'b01;
      cyc();
      chk("rd_g0", grant_o, 2'b01);
      ack_i = 1'b1;
      #1 chk("rd_acc0", acc_o, 1'b1);
      chk("rd_we0", we_o, 1'b0);
      cyc();
      ack_i = 1'b0; p_acc_i = 2'b10;
      cyc();
      cyc();
      chk("rd_g1", grant_o, 2'b10);
      ack_i = 1'b1;
      cyc();
      ack_i = 1'b0; p_acc_i = 2'b00;
      cyc();
      for (int b = 0; b < 16; b++) begin
         vld_i = 1'b1;
         dat_i = 16'hA000 + 16'(b);
         adr_i = 32'h4000 + 32'(b);
         #1;
         chk("steer_vld", p_vld_o, (b < 8) ? 2'b01 : 2'b10);
         chk("steer_dat", p_dat_o, 16'hA000 + 16'(b));
         chk("steer_adr", p_adr_o, 32'h4000 + 32'(b));
         cyc();
      end
      vld_i = 1'b0;
      #1 chk("steer_done", p_vld_o, 2'b00);
      vld_i = 1'b1;
      #1 chk("vld_empty_drop", p_vld_o, 2'b00);
      cyc();
      vld_i = 1'b0;

      // FIFO full: four port0 reads outstanding
      p_acc_i = 2'b01;
      cyc();
      chk("full_g0", grant_o, 2'b01);
      ack_i = 1'b1;
      repeat (4) cyc();
      ack_i = 1'b0;
      #1 chk("full_block", acc_o, 1'b0);
      cyc();
      chk("full_block_hold", acc_o, 1'b0);
      chk("full_grant_hold", grant_o, 2'b01);
      p_we_i = 2'b01; p_dv_i = 2'b01;
      #1 chk("full_write_acc", acc_o, 1'b1);
      chk("full_write_dv", dv_o, 1'b1);
      ack_i = 1'b1;
      #1 chk("full_write_ack", p_ack_o, 2'b01);
      cyc();
      ack_i = 1'b0; p_we_i = 2'b00; p_dv_i = 2'b00;
      #1 chk("full_after_write", acc_o, 1'b0);
      for (int b = 0; b < 8; b++) begin
         vld_i = 1'b1;
         #1;
         chk("full_pop_vld", p_vld_o, 2'b01);
         chk("full_wait_pop", acc_o, 1'b0);
         cyc();
      end
      vld_i = 1'b0;
      #1 chk("unblock_after_pop", acc_o, 1'b1);

      // simultaneous push and pop: FIFO [0,0,0] -> [0,0,1]
      p_acc_i = 2'b10;
      cyc();
      cyc();
      chk("pp_g1", grant_o, 2'b10);
      chk("pp_acc1", acc_o, 1'b1);
      for (int b = 0; b < 7; b++) begin
         vld_i = 1'b1;
         #1 chk("pp_vld", p_vld_o, 2'b01);
         cyc();
      end
      vld_i = 1'b1; ack_i = 1'b1;
      #1 chk("pp_last_vld", p_vld_o, 2'b01);
      chk("pp_ack", p_ack_o, 2'b10);
      cyc();
      vld_i = 1'b0; ack_i = 1'b0;
      #1 chk("pushpop_count", acc_o, 1'b1);
      p_acc_i = 2'b00;
      cyc();
      for (int b = 0; b < 24; b++) begin
         vld_i = 1'b1;
         #1 chk("drain_vld", p_vld_o, (b < 16) ? 2'b01 : 2'b10);
         cyc();
      end
      #1 chk("drain_empty", p_vld_o, 2'b00);
      vld_i = 1'b0;
      cyc();

      // asynchronous reset mid-BUSY with two reads outstanding
      p_acc_i = 2'b01;
      cyc();
      chk("prerst_g0", grant_o, 2'b01);
      ack_i = 1'b1;
      cyc();
      cyc();
      ack_i = 1'b0; vld_i = 1'b1;
      #1 chk("prerst_vld", p_vld_o, 2'b01);
      sdram_rst_n = 1'b0; ack_i = 1'b1;
      #1;
      chk("midrst_grant", grant_o, 2'b00);
      chk("midrst_acc", acc_o, 1'b0);
      chk("midrst_adr", adr_o, 32'h0);
      chk("midrst_we", we_o, 1'b0);
      chk("midrst_ack", p_ack_o, 2'b00);
      chk("midrst_vld", p_vld_o, 2'b00);
      #1;
      sdram_rst_n = 1'b1; ack_i = 1'b0; vld_i = 1'b0;
      cyc();
      chk("postrst_grant", grant_o, 2'b01);
      vld_i = 1'b1;
      #1 chk("postrst_fifo_empty", p_vld_o, 2'b00);
      vld_i = 1'b0; p_acc_i = 2'b00;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
